// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Groups the datapath request/response handshake and the req/ack data-memory
// port of the load/store unit into one bundle.
//   slave  modport : the load/store unit's view (requests in, memory out)
//   master modport : the environment's view (datapath + memory model)
// Signals:
//   lsu_valid/lsu_write/lsu_funct3/lsu_addr/lsu_wdata : request from datapath
//   lsu_ready/lsu_stall/lsu_done/lsu_rdata/lsu_fault/lsu_fault_cause : status
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : memory request
//   mem_ack/mem_rdata : memory response
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int WORDSIZE = 64
);
    logic                lsu_valid;
    logic                lsu_write;
    logic [2:0]          lsu_funct3;
    logic [WORDSIZE-1:0] lsu_addr;
    logic [WORDSIZE-1:0] lsu_wdata;
    logic                lsu_ready;
    logic                lsu_stall;
    logic                lsu_done;
    logic [WORDSIZE-1:0] lsu_rdata;
    logic                lsu_fault;
    logic [1:0]          lsu_fault_cause;
    logic                mem_req;
    logic                mem_we;
    logic [WORDSIZE-1:0] mem_addr;
    logic [WORDSIZE-1:0] mem_wdata;
    logic [7:0]          mem_wstrb;
    logic                mem_ack;
    logic [WORDSIZE-1:0] mem_rdata;

    modport slave (
        input  lsu_valid, lsu_write, lsu_funct3, lsu_addr, lsu_wdata,
        input  mem_ack, mem_rdata,
        output lsu_ready, lsu_stall, lsu_done, lsu_rdata, lsu_fault, lsu_fault_cause,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output lsu_valid, lsu_write, lsu_funct3, lsu_addr, lsu_wdata,
        output mem_ack, mem_rdata,
        input  lsu_ready, lsu_stall, lsu_done, lsu_rdata, lsu_fault, lsu_fault_cause,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Accepts one load/store per handshake from the execute stage, issues it on a
// variable-latency req/ack memory port with 8-byte-aligned addressing and byte
// strobes, stalls the datapath until completion, and returns a sign- or
// zero-extended load result or a fault (misaligned, illegal funct3, timeout).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : load_store_unit_if.slave (datapath handshake + memory port)
// Parameters:
//   WORDSIZE : data/address width (byte-lane logic assumes 64)
//   MAX_WAIT : cycles mem_req may stay unacknowledged before a timeout fault
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int WORDSIZE = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    load_store_unit_if.slave        bus
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [WORDSIZE-1:0] addr_q, addr_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;
    logic [7:0]          wstrb_q, wstrb_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [2:0]          off_q, off_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [WORDSIZE-1:0] rdata_q, rdata_d;
    logic                fault_q, fault_d;
    logic [1:0]          cause_q, cause_d;

    logic [2:0]          req_off;
    logic [1:0]          req_size;
    logic                req_illegal;
    logic                req_misaligned;
    logic [7:0]          req_strb;
    logic [WORDSIZE-1:0] req_wdata;
    logic [WORDSIZE-1:0] ld_shifted;
    logic [WORDSIZE-1:0] ld_result;

    // Decode the incoming request: size, legality, alignment and the
    // lane-shifted store data/strobe it would put on the bus.
    always_comb begin
        req_off        = bus.lsu_addr[2:0];
        req_size       = bus.lsu_funct3[1:0];
        // Stores have no unsigned variants, so any funct3[2] is illegal there.
        req_illegal    = bus.lsu_write ? bus.lsu_funct3[2] : (bus.lsu_funct3 == 3'b111);
        req_misaligned = 1'b0;
        req_strb       = 8'h00;
        case (req_size)
            2'b00: begin
                req_misaligned = 1'b0;
                req_strb       = 8'h01;
            end
            2'b01: begin
                req_misaligned = req_off[0];
                req_strb       = 8'h03;
            end
            2'b10: begin
                req_misaligned = |req_off[1:0];
                req_strb       = 8'h0F;
            end
            default: begin
                req_misaligned = |req_off;
                req_strb       = 8'hFF;
            end
        endcase
        req_strb  = req_strb << req_off;
        req_wdata = bus.lsu_wdata << {req_off, 3'b000};
    end

    // Align the returned memory word to the accessed bytes and extend it.
    always_comb begin
        ld_shifted = bus.mem_rdata >> {off_q, 3'b000};
        ld_result  = ld_shifted;
        case (size_q)
            2'b00:   ld_result = uns_q ? {{(WORDSIZE-8){1'b0}}, ld_shifted[7:0]}
                                       : {{(WORDSIZE-8){ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01:   ld_result = uns_q ? {{(WORDSIZE-16){1'b0}}, ld_shifted[15:0]}
                                       : {{(WORDSIZE-16){ld_shifted[15]}}, ld_shifted[15:0]};
            2'b10:   ld_result = uns_q ? {{(WORDSIZE-32){1'b0}}, ld_shifted[31:0]}
                                       : {{(WORDSIZE-32){ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_result = ld_shifted;
        endcase
    end

    // Next-state logic for the IDLE -> REQ -> DONE sequence and everything
    // captured along the way.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cause_d = cause_q;

        case (state_q)
            IDLE: begin
                if (bus.lsu_valid) begin
                    if (req_illegal || req_misaligned) begin
                        // Illegal funct3 outranks misalignment; no memory access.
                        state_d = DONE;
                        fault_d = 1'b1;
                        cause_d = req_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = bus.lsu_write;
                        addr_d  = {bus.lsu_addr[WORDSIZE-1:3], 3'b000};
                        wdata_d = bus.lsu_write ? req_wdata : '0;
                        wstrb_d = bus.lsu_write ? req_strb : 8'h00;
                        size_d  = req_size;
                        uns_d   = bus.lsu_funct3[2];
                        off_d   = req_off;
                        wait_d  = '0;
                        fault_d = 1'b0;
                        cause_d = CAUSE_NONE;
                    end
                end
            end
            REQ: begin
                // An ack in the final allowed cycle still completes normally.
                if (bus.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = ld_result;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                fault_d = 1'b0;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    // State register; reset also drops mem_req immediately mid-transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 8'h00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 3'b000;
            wait_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign bus.lsu_ready       = (state_q == IDLE);
    assign bus.lsu_stall       = ((state_q == IDLE) && bus.lsu_valid) || (state_q == REQ);
    assign bus.lsu_done        = (state_q == DONE);
    assign bus.lsu_rdata       = rdata_q;
    assign bus.lsu_fault       = (state_q == DONE) && fault_q;
    assign bus.lsu_fault_cause = (state_q == DONE) ? cause_q : CAUSE_NONE;
    assign bus.mem_req         = req_q;
    assign bus.mem_we          = we_q;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_wstrb       = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Table-driven directed bench for load_store_unit (MAX_WAIT=4) with
// hand-written sequences for timeout, late ack and reset during REQ.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    load_store_unit_if #(.WORDSIZE(64)) bus ();

    load_store_unit #(.WORDSIZE(64), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] memRdata;
        int          delay;
        logic        expFault;
        logic [1:0]  expCause;
        logic [63:0] expRdata;
        logic [63:0] expMemAddr;
        logic [63:0] expMemWdata;
        logic [7:0]  expWstrb;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Runs one table entry through a full handshake, acting as both the
    // datapath and the memory, and compares everything it observes.
    task automatic applyStimulus(input vec_t v, input int idx);
        int          reqCount;
        int          doneCycle;
        logic        sawDone;
        logic        stable;
        logic [63:0] capAddr;
        logic [63:0] capWdata;
        logic [7:0]  capStrb;
        logic        capWe;
        reqCount  = 0;
        doneCycle = 0;
        sawDone   = 1'b0;
        stable    = 1'b1;
        capAddr   = '0;
        capWdata  = '0;
        capStrb   = '0;
        capWe     = 1'b0;

        @(negedge clk);
        bus.lsu_valid  = 1'b1;
        bus.lsu_write  = v.wr;
        bus.lsu_funct3 = v.f3;
        bus.lsu_addr   = v.addr;
        bus.lsu_wdata  = v.wdata;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = v.memRdata;
        #1;
        checkOutput($sformatf("v%0d_ready", idx), {63'd0, bus.lsu_ready}, 64'd1);
        checkOutput($sformatf("v%0d_stall_idle", idx), {63'd0, bus.lsu_stall}, 64'd1);

        for (int c = 1; c <= 12 && !sawDone; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.lsu_done) begin
                sawDone   = 1'b1;
                doneCycle = c;
                checkOutput($sformatf("v%0d_fault", idx), {63'd0, bus.lsu_fault}, {63'd0, v.expFault});
                checkOutput($sformatf("v%0d_cause", idx), {62'd0, bus.lsu_fault_cause}, {62'd0, v.expCause});
                checkOutput($sformatf("v%0d_rdata", idx), bus.lsu_rdata, v.expRdata);
                checkOutput($sformatf("v%0d_stall_done", idx), {63'd0, bus.lsu_stall}, 64'd0);
                bus.lsu_valid = 1'b0;
            end else if (bus.mem_req) begin
                reqCount++;
                if (reqCount == 1) begin
                    capAddr  = bus.mem_addr;
                    capWdata = bus.mem_wdata;
                    capStrb  = bus.mem_wstrb;
                    capWe    = bus.mem_we;
                end else if (capAddr !== bus.mem_addr || capWdata !== bus.mem_wdata ||
                             capStrb !== bus.mem_wstrb || capWe !== bus.mem_we) begin
                    stable = 1'b0;
                end
                if (reqCount == v.delay + 1) bus.mem_ack = 1'b1;
            end
        end
        if (!sawDone) bus.lsu_valid = 1'b0;

        checkOutput($sformatf("v%0d_done_seen", idx), {63'd0, sawDone}, 64'd1);
        checkOutput($sformatf("v%0d_done_cycle", idx), 64'(doneCycle),
                    v.expFault ? 64'd1 : 64'(v.delay + 2));
        checkOutput($sformatf("v%0d_req_cycles", idx), 64'(reqCount),
                    v.expFault ? 64'd0 : 64'(v.delay + 1));
        if (!v.expFault) begin
            checkOutput($sformatf("v%0d_mem_addr", idx), capAddr, v.expMemAddr);
            checkOutput($sformatf("v%0d_mem_wstrb", idx), {56'd0, capStrb}, {56'd0, v.expWstrb});
            checkOutput($sformatf("v%0d_mem_we", idx), {63'd0, capWe}, {63'd0, v.wr});
            checkOutput($sformatf("v%0d_mem_stable", idx), {63'd0, stable}, 64'd1);
            if (v.wr) checkOutput($sformatf("v%0d_mem_wdata", idx), capWdata, v.expMemWdata);
        end

        @(negedge clk);
        checkOutput($sformatf("v%0d_post_done", idx), {63'd0, bus.lsu_done}, 64'd0);
        checkOutput($sformatf("v%0d_post_fault", idx), {63'd0, bus.lsu_fault}, 64'd0);
        checkOutput($sformatf("v%0d_post_ready", idx), {63'd0, bus.lsu_ready}, 64'd1);
        checkOutput($sformatf("v%0d_rdata_hold", idx), bus.lsu_rdata, v.expRdata);
    endtask

    initial begin
        int          reqCount;
        logic        sawDone;
        logic        sawLateDone;

        checks   = 0;
        failures = 0;

        //            wr    f3      addr    wdata                  memRdata               dly flt cause  expRdata               memAddr  memWdata               strb
        vecs[0]  = '{1'b0, 3'b011, 64'h10, 64'h0,                 64'h1122334455667788,  2, 1'b0, 2'b00, 64'h1122334455667788, 64'h10, 64'h0,                 8'h00};
        vecs[1]  = '{1'b0, 3'b000, 64'h13, 64'h0,                 64'h0000000080000000,  0, 1'b0, 2'b00, 64'hFFFFFFFFFFFFFF80, 64'h10, 64'h0,                 8'h00};
        vecs[2]  = '{1'b0, 3'b100, 64'h13, 64'h0,                 64'h0000000080000000,  0, 1'b0, 2'b00, 64'h0000000000000080, 64'h10, 64'h0,                 8'h00};
        vecs[3]  = '{1'b1, 3'b001, 64'h0A, 64'hBEEF,              64'h0,                 1, 1'b0, 2'b00, 64'h0000000000000080, 64'h08, 64'h00000000BEEF0000, 8'h0C};
        vecs[4]  = '{1'b0, 3'b010, 64'h06, 64'h0,                 64'h0,                 0, 1'b1, 2'b01, 64'h0000000000000080, 64'h0,  64'h0,                 8'h00};
        vecs[5]  = '{1'b0, 3'b111, 64'h06, 64'h0,                 64'h0,                 0, 1'b1, 2'b10, 64'h0000000000000080, 64'h0,  64'h0,                 8'h00};
        vecs[6]  = '{1'b1, 3'b100, 64'h08, 64'h55,                64'h0,                 0, 1'b1, 2'b10, 64'h0000000000000080, 64'h0,  64'h0,                 8'h00};
        vecs[7]  = '{1'b0, 3'b001, 64'h1E, 64'h0,                 64'h8001000000000000,  1, 1'b0, 2'b00, 64'hFFFFFFFFFFFF8001, 64'h18, 64'h0,                 8'h00};
        vecs[8]  = '{1'b0, 3'b101, 64'h1E, 64'h0,                 64'h8001000000000000,  0, 1'b0, 2'b00, 64'h0000000000008001, 64'h18, 64'h0,                 8'h00};
        vecs[9]  = '{1'b0, 3'b010, 64'h24, 64'h0,                 64'hDEADBEEF00000000,  3, 1'b0, 2'b00, 64'hFFFFFFFFDEADBEEF, 64'h20, 64'h0,                 8'h00};
        vecs[10] = '{1'b0, 3'b110, 64'h24, 64'h0,                 64'hDEADBEEF00000000,  0, 1'b0, 2'b00, 64'h00000000DEADBEEF, 64'h20, 64'h0,                 8'h00};
        vecs[11] = '{1'b1, 3'b011, 64'h18, 64'h0123456789ABCDEF,  64'h0,                 0, 1'b0, 2'b00, 64'h00000000DEADBEEF, 64'h18, 64'h0123456789ABCDEF, 8'hFF};
        vecs[12] = '{1'b1, 3'b000, 64'h07, 64'h11223344556677AB,  64'h0,                 2, 1'b0, 2'b00, 64'h00000000DEADBEEF, 64'h00, 64'hAB00000000000000, 8'h80};
        vecs[13] = '{1'b1, 3'b010, 64'h04, 64'hCAFEF00D,          64'h0,                 0, 1'b0, 2'b00, 64'h00000000DEADBEEF, 64'h00, 64'hCAFEF00D00000000, 8'hF0};
        vecs[14] = '{1'b1, 3'b011, 64'h1C, 64'h1,                 64'h0,                 0, 1'b1, 2'b01, 64'h00000000DEADBEEF, 64'h0,  64'h0,                 8'h00};

        rst            = 1'b1;
        bus.lsu_valid  = 1'b0;
        bus.lsu_write  = 1'b0;
        bus.lsu_funct3 = 3'b000;
        bus.lsu_addr   = '0;
        bus.lsu_wdata  = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ready", {63'd0, bus.lsu_ready}, 64'd1);
        checkOutput("reset_stall", {63'd0, bus.lsu_stall}, 64'd0);
        checkOutput("reset_done", {63'd0, bus.lsu_done}, 64'd0);
        checkOutput("reset_mem_req", {63'd0, bus.mem_req}, 64'd0);
        checkOutput("reset_rdata", bus.lsu_rdata, 64'd0);
        checkOutput("reset_fault", {63'd0, bus.lsu_fault}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Timeout: an LD that is never acknowledged.
        @(negedge clk);
        bus.lsu_valid  = 1'b1;
        bus.lsu_write  = 1'b0;
        bus.lsu_funct3 = 3'b011;
        bus.lsu_addr   = 64'h20;
        bus.mem_ack    = 1'b0;
        reqCount = 0;
        sawDone  = 1'b0;
        for (int c = 1; c <= 12 && !sawDone; c++) begin
            @(negedge clk);
            if (bus.lsu_done) begin
                sawDone = 1'b1;
                checkOutput("timeout_fault", {63'd0, bus.lsu_fault}, 64'd1);
                checkOutput("timeout_cause", {62'd0, bus.lsu_fault_cause}, 64'd3);
                checkOutput("timeout_rdata", bus.lsu_rdata, 64'h00000000DEADBEEF);
                bus.lsu_valid = 1'b0;
            end else if (bus.mem_req) begin
                reqCount++;
            end
        end
        bus.lsu_valid = 1'b0;
        checkOutput("timeout_done_seen", {63'd0, sawDone}, 64'd1);
        checkOutput("timeout_req_cycles", 64'(reqCount), 64'd4);

        // A late ack arriving while IDLE must be ignored.
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checkOutput("late_ack_done", {63'd0, bus.lsu_done}, 64'd0);
        checkOutput("late_ack_ready", {63'd0, bus.lsu_ready}, 64'd1);
        checkOutput("late_ack_req", {63'd0, bus.mem_req}, 64'd0);
        checkOutput("late_ack_rdata", bus.lsu_rdata, 64'h00000000DEADBEEF);

        // Reset pulse in the middle of REQ.
        @(negedge clk);
        bus.lsu_valid  = 1'b1;
        bus.lsu_write  = 1'b0;
        bus.lsu_funct3 = 3'b011;
        bus.lsu_addr   = 64'h28;
        @(negedge clk);
        checkOutput("rst_req_before", {63'd0, bus.mem_req}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_req_async", {63'd0, bus.mem_req}, 64'd0);
        checkOutput("rst_ready_async", {63'd0, bus.lsu_ready}, 64'd1);
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h1234;
        sawLateDone   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.lsu_done) sawLateDone = 1'b1;
        end
        checkOutput("rst_no_done", {63'd0, sawLateDone}, 64'd0);
        checkOutput("rst_rdata", bus.lsu_rdata, 64'd0);
        checkOutput("rst_idle_ready", {63'd0, bus.lsu_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
